// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned umax(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce FSM and hold-repeat counter.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel_pulse
);

  localparam int unsigned DbW    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RepW   = cnt_width(umax(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit          DbOnly = (DEBOUNCE_CYCLES == 1);
  localparam bit          RepEn  = (REPEAT_DELAY > 0);

  localparam logic [DbW-1:0]  DbOne     = DbW'(1);
  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] RepOne    = RepW'(1);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_e             state_q, state_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [RepW-1:0]        rep_cnt_q, rep_cnt_d;
  logic                   rep_armed_q, rep_armed_d;
  logic                   pulse_q, pulse_d;
  logic                   rel_q, rel_d;
  logic [RepW-1:0]        rep_target;
  logic                   rep_fire;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      pulse_q     <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      pulse_q     <= pulse_d;
      rel_q       <= rel_d;
    end
  end

  // Repeat counter reloads after each pulse, so it never exceeds the larger interval.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    rep_target  = rep_armed_q ? RepPeriod : RepDelay;
    if (RepEn && (state_q == HELD || state_q == RELEASE_WAIT)) begin
      if (rep_cnt_q >= rep_target - RepOne) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RepOne;
      end
    end

    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pulse_d  = 1'b0;
    rel_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        if (s) begin
          if (DbOnly) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end else begin
            state_d  = PRESS_WAIT;
            db_cnt_d = DbOne;
          end
        end
      end
      PRESS_WAIT: begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        if (!s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          state_d  = HELD;
          db_cnt_d = '0;
          pulse_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      HELD: begin
        pulse_d = rep_fire;
        if (!s) begin
          if (DbOnly) begin
            state_d     = IDLE;
            rel_d       = 1'b1;
            pulse_d     = 1'b0;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
          end else begin
            state_d  = RELEASE_WAIT;
            db_cnt_d = DbOne;
          end
        end
      end
      RELEASE_WAIT: begin
        pulse_d = rep_fire;
        if (s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          // An accepted release wins over a coinciding repeat.
          state_d     = IDLE;
          db_cnt_d    = '0;
          rel_d       = 1'b1;
          pulse_d     = 1'b0;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DbOne;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign level     = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign pulse     = pulse_q;
  assign rel_pulse = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// N independent push-button channels: synchronise, debounce, press/release/repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 25000000
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] A,
  output logic [N-1:0] A_level,
  output logic [N-1:0] A_pulse,
  output logic [N-1:0] A_release
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock    (Clock),
      .reset    (Reset),
      .raw      (A[g]),
      .level    (A_level[g]),
      .pulse    (A_pulse[g]),
      .rel_pulse(A_release[g])
    );
  end

endmodule
